pulse_gen: RTL
==============

PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 50000000, meaning window length in clk cycles (must be >= 2 and even).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of pulse-count values.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port run  input  1  level request to generate windows.
REQ-006 SHALL have port cfg_valid  input  1  new pulse count offered.
REQ-007 SHALL have port cfg_count  input  CNT_W  requested rising edges per window.
REQ-008 SHALL have port cfg_ready  output  1  block can accept cfg_count.
REQ-009 SHALL have port fout  output  1  generated square-wave output, registered.
REQ-010 SHALL have port win_start  output  1  one-cycle pulse on first cycle of each window.
REQ-011 SHALL have port busy  output  1  high in RUN or STOP state.
REQ-012 SHALL have port active_count  output  CNT_W  count governing the current/next window.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, STOP; IDLE->RUN when run=1; RUN->STOP when run=0; STOP->RUN when run=1 (no gap); STOP->IDLE on the last cycle of the current window.
REQ-014 SHALL hold fout=0, window counter=0, accumulator=0 in IDLE.
REQ-015 SHALL enter RUN one cycle after run is sampled high in IDLE, with win_start=1 in that first RUN cycle.
REQ-016 SHALL count window cycles 0..GATE_CYCLES-1, wrapping to 0 and asserting win_start when the count is 0 while busy.
REQ-017 SHALL use a Bresenham accumulator: each window cycle add 2*active_count; when sum >= GATE_CYCLES subtract GATE_CYCLES and toggle fout.
REQ-018 SHALL clear the accumulator and force fout=0 at each window start, so every window shows exactly active_count rising edges and fout is 0 in cycle 0 of the next window.
REQ-019 SHALL clamp accepted cfg_count to GATE_CYCLES/2 (at most one toggle per cycle).
REQ-020 SHALL drive cfg_ready=1 when no update is pending; a transfer occurs on cfg_valid&&cfg_ready.
REQ-021 SHALL, in IDLE, load an accepted value directly into active_count with no pending flag.
REQ-022 SHALL, when busy, store an accepted value in a shadow register, set pending (cfg_ready=0), and load it into active_count at the next window start, then clear pending.
REQ-023 SHALL apply a value accepted in the same cycle as a window-start load at the following window start.
REQ-024 SHALL keep fout=0 for the whole window when active_count=0.
REQ-025 SHALL size the accumulator to hold GATE_CYCLES + 2*max count without overflow.
REQ-026 SHALL finish the window in progress in STOP with full pulse count, then return to IDLE with fout=0.

Reset
REQ-027 SHALL on rst_n low force state=IDLE, fout=0, win_start=0, busy=0, cfg_ready=1, active_count=0, shadow=0, pending=0, accumulator=0, window counter=0, immediately and asynchronously.
REQ-028 SHALL resume only via a fresh IDLE->RUN transition after rst_n deasserts; an interrupted window is not completed.

Structure
REQ-029 SHALL place the state encoding, CNT_W default and GATE_CYCLES default in shared package freq_pkg.
REQ-030 SHALL implement the window counter and win_start generation as sub-module gate_timer (inputs clk, rst_n, en; outputs win_start, last_cycle).

Verification (GATE_CYCLES=20)
REQ-031 SHALL check: cfg_count=3 in IDLE, run=1 -> win_start every 20 cycles, exactly 3 fout rising edges per window, fout=0 at each win_start.
REQ-032 SHALL check: cfg_count=10 -> fout toggles every cycle (period 2), 10 rising edges per window; cfg_count=15 -> clamped, active_count=10.
REQ-033 SHALL check: while running with count 3, accept count 5 mid-window -> cfg_ready=0 until next win_start, that window 3 edges, next window 5 edges.
REQ-034 SHALL check: run dropped at window cycle 7 -> window completes with 3 edges, busy falls after cycle 19, fout=0; run re-raised at cycle 12 -> next window starts without gap.
REQ-035 SHALL check: cfg_count=0 -> fout constant 0 for whole window, win_start still pulses.
REQ-036 SHALL check: rst_n pulsed low mid-window -> all outputs at reset values same cycle, cfg_ready=1, restart requires run sampled high.

Source files
------------

// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared defaults, FSM state encoding and sizing helper for pulse_gen
package freq_pkg;

  localparam int unsigned GATE_CYCLES_DEF = 50000000;
  localparam int unsigned CNT_W_DEF       = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  // Accumulator holds at most (GATE_CYCLES-1) + 2*(GATE_CYCLES/2) before subtraction.
  function automatic int unsigned acc_bits(input int unsigned gate);
    return $clog2(2 * gate + 1);
  endfunction

endpackage

// File: rtl/gate_timer.sv
// rtl/gate_timer.sv - window cycle counter producing win_start and last_cycle strobes
module gate_timer
  import freq_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic win_start,
  output logic last_cycle
);

  localparam int unsigned CW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(GATE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign win_start  = en && (cnt_q == '0);
  assign last_cycle = en && (cnt_q == LAST);

endmodule

// File: rtl/pulse_gen.sv
// rtl/pulse_gen.sv - gated-window square-wave generator with exact rising-edge count per window
module pulse_gen
  import freq_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_count,
  output logic             cfg_ready,
  output logic             fout,
  output logic             win_start,
  output logic             busy,
  output logic [CNT_W-1:0] active_count
);

  localparam int unsigned ACC_W = acc_bits(GATE_CYCLES);
  localparam int unsigned HALF  = GATE_CYCLES / 2;
  localparam logic [ACC_W-1:0] G_ACC = ACC_W'(GATE_CYCLES);

  state_e state_q, state_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             fout_q, fout_d;

  logic             last_cycle;
  logic             accept;
  logic [CNT_W-1:0] cfg_clamped;
  logic [ACC_W-1:0] step;
  logic [ACC_W-1:0] sum;

  assign busy = (state_q != ST_IDLE);

  gate_timer #(
    .GATE_CYCLES(GATE_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (busy),
    .win_start (win_start),
    .last_cycle(last_cycle)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_RUN;
      // Dropping run on the final cycle needs no STOP: the window is already complete.
      ST_RUN:  if (!run) state_d = last_cycle ? ST_IDLE : ST_STOP;
      ST_STOP: begin
        if (run) begin
          state_d = ST_RUN;
        end else if (last_cycle) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // More than one toggle per cycle is impossible, so GATE_CYCLES/2 is the ceiling.
  always_comb begin
    cfg_clamped = cfg_count;
    if (32'(cfg_count) > HALF) begin
      cfg_clamped = CNT_W'(HALF);
    end
  end

  assign cfg_ready = !pending_q;
  assign accept    = cfg_valid && cfg_ready;

  // active_count only changes outside a window or on its last cycle, so it is stable per window.
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (!busy) begin
      if (accept) active_d = cfg_clamped;
    end else if (last_cycle) begin
      if (pending_q) begin
        active_d = shadow_q;
      end else if (accept) begin
        active_d = cfg_clamped;
      end
      pending_d = 1'b0;
    end else if (accept) begin
      shadow_d  = cfg_clamped;
      pending_d = 1'b1;
    end
  end

  assign step = ACC_W'({active_q, 1'b0});
  assign sum  = acc_q + step;

  // Clearing on the last cycle makes fout 0 and the accumulator empty in cycle 0 of every window.
  always_comb begin
    acc_d  = '0;
    fout_d = 1'b0;
    if (busy && !last_cycle) begin
      if (sum >= G_ACC) begin
        acc_d  = sum - G_ACC;
        fout_d = ~fout_q;
      end else begin
        acc_d  = sum;
        fout_d = fout_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      acc_q     <= '0;
      fout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      acc_q     <= acc_d;
      fout_q    <= fout_d;
    end
  end

  assign fout         = fout_q;
  assign active_count = active_q;

endmodule
